morse_char_sequencer: RTL and testbench
=======================================

Name: morse_char_sequencer

Overview:
Accepts one character code at a time from an upstream requester over a valid/ready handshake. Expands each code into its ITU Morse element sequence. Drives the one-cycle dot/dash/char-space/word-space strobes of the Morse translator FSM, spacing the strobes so the translator always returns to idle before the next strobe arrives. The block sits between the character source and the translator and owns all inter-strobe timing.

Parameters:
GAP_CYCLES, 4, cycles from one output strobe to the next. Legal range 2..255; 2 is the translator's minimum turnaround.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
char_valid  input  1  requester has a code on char_code
char_code  input  6  0-25 = A-Z; 26-35 = digits 0-9 (26+d); 36 = word space; 37-63 = invalid
char_ready  output  1  high only in IDLE; code is accepted on a clock edge where char_valid and char_ready are both 1
dot_out  output  1  one-cycle dot strobe to translator
dash_out  output  1  one-cycle dash strobe to translator
char_space_out  output  1  one-cycle character-space strobe
word_space_out  output  1  one-cycle word-space strobe
busy  output  1  equals NOT char_ready
err  output  1  one-cycle pulse when an invalid code is accepted

Behaviour:
- Reset (rst=0, asynchronous):
  - state = IDLE; all strobes and err = 0; gap counter = 0; pattern registers = 0.
  - char_ready = 1 while in reset and immediately after reset.
- Pattern lookup: combinational ROM indexed by char_code.
  - Output is len (1..5) and pat[4:0], sent MSB-first, where 1 = dash and 0 = dot.
  - Contents are standard ITU Morse, e.g. E=., T=-, A=.-, S=..., O=---, 0=-----, 5=......
  - Pattern and length are registered on accept; later changes on char_code have no effect.
- States: IDLE, ELEM, GAP, CSPACE, WSPACE, ERR.
- Transitions:
  - IDLE: on accept, go to ELEM (codes 0-35), WSPACE (code 36) or ERR (codes 37-63). Otherwise stay in IDLE.
  - ELEM: assert exactly one of dot_out/dash_out for the current element, decrement remaining count, then go to GAP.
  - GAP: hold for GAP_CYCLES-1 cycles with no strobes. Then go to ELEM if elements remain, CSPACE if the character is finished, or IDLE if the last strobe was char-space or word-space.
  - CSPACE: assert char_space_out for one cycle, then go to GAP.
  - WSPACE: assert word_space_out for one cycle, then go to GAP.
  - ERR: assert err for one cycle, then go to IDLE.
- Timing, with accept at edge ending cycle T and G = GAP_CYCLES:
  - Element k (k = 0..n-1) strobes at cycle T+1+kG.
  - char_space_out strobes at T+1+nG.
  - char_ready returns high at T+1+(n+1)G.
  - Word space: word_space_out at T+1, ready at T+1+G.
  - Invalid code: err at T+1, ready at T+2.
  - No strobes ever occur for invalid codes.
- Invariants:
  - At most one of the four strobes is high in any cycle.
  - Consecutive strobes are exactly G cycles apart.
  - Strobes are registered outputs.
- Gap counter is 8 bits, loaded with G-1 on entry to GAP and counted down to 0.
- char_valid while busy: ignored and not accepted. A code held valid is accepted on the first cycle ready returns.
- Back-to-back characters: the next accept may occur in the same cycle ready rises. Its first strobe then follows one cycle later, so the gap to the previous char-space strobe is G+1.
- Reset mid-character: all strobes drop at once. The pending character is discarded (not resumed); IDLE and ready=1 after reset.

Test Plan:
- G=4, accept 'E' (4) at T → dot_out@T+1; char_space_out@T+5; char_ready=1@T+9; no other strobes.
- G=4, accept 'A' (0) → dot@T+1, dash@T+5, char_space@T+9, ready@T+13.
- G=2, accept '0' (26), then code 36 held valid → dashes@T+1,3,5,7,9; char_space@T+11; ready@T+13, accepted there; word_space_out@T+14.
- Accept code 40 → err@T+1, no strobes, ready@T+2. Also drive char_code/char_valid changes while busy → no extra accepts and the pattern is unchanged.
- G=4, accept 'S' (18); assert rst=0 at T+6 → all outputs 0 immediately; after release, char_ready=1 and no further strobes from 'S'.
- Randomised stream of codes 0-36 at G=2 → checker confirms one-hot strobes, exact G spacing, and that translator outputs reproduce the ITU sequence.

Source files
------------

// File: rtl/morse_char_sequencer.sv
// Expands one character code into ITU Morse dot/dash/space strobes for the
// translator FSM, spacing consecutive strobes exactly GAP_CYCLES apart.
module morse_char_sequencer #(
    parameter int GAP_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       char_valid,
    input  logic [5:0] char_code,
    output logic       char_ready,
    output logic       dot_out,
    output logic       dash_out,
    output logic       char_space_out,
    output logic       word_space_out,
    output logic       busy,
    output logic       err
);

    typedef enum logic [2:0] {IDLE, ELEM, GAP, CSPACE, WSPACE, ERR} state_t;

    state_t     state_q, state_d;
    logic [4:0] pat_q, pat_d;
    logic [2:0] rem_q, rem_d;
    logic [7:0] gap_q, gap_d;
    logic       sp_q, sp_d;
    logic       dot_q, dot_d, dash_q, dash_d, cs_q, cs_d, ws_q, ws_d, err_q, err_d;
    logic [2:0] rom_len;
    logic [4:0] rom_raw, rom_pat;
    logic       accept;

    assign accept = char_valid && (state_q == IDLE);

    // ROM holds patterns right-aligned (last element in bit 0); 1 = dash
    always_comb begin
        {rom_len, rom_raw} = 8'd0;
        case (char_code)
            6'd0:  {rom_len, rom_raw} = {3'd2, 5'b00001}; // A
            6'd1:  {rom_len, rom_raw} = {3'd4, 5'b01000}; // B
            6'd2:  {rom_len, rom_raw} = {3'd4, 5'b01010}; // C
            6'd3:  {rom_len, rom_raw} = {3'd3, 5'b00100}; // D
            6'd4:  {rom_len, rom_raw} = {3'd1, 5'b00000}; // E
            6'd5:  {rom_len, rom_raw} = {3'd4, 5'b00010}; // F
            6'd6:  {rom_len, rom_raw} = {3'd3, 5'b00110}; // G
            6'd7:  {rom_len, rom_raw} = {3'd4, 5'b00000}; // H
            6'd8:  {rom_len, rom_raw} = {3'd2, 5'b00000}; // I
            6'd9:  {rom_len, rom_raw} = {3'd4, 5'b00111}; // J
            6'd10: {rom_len, rom_raw} = {3'd3, 5'b00101}; // K
            6'd11: {rom_len, rom_raw} = {3'd4, 5'b00100}; // L
            6'd12: {rom_len, rom_raw} = {3'd2, 5'b00011}; // M
            6'd13: {rom_len, rom_raw} = {3'd2, 5'b00010}; // N
            6'd14: {rom_len, rom_raw} = {3'd3, 5'b00111}; // O
            6'd15: {rom_len, rom_raw} = {3'd4, 5'b00110}; // P
            6'd16: {rom_len, rom_raw} = {3'd4, 5'b01101}; // Q
            6'd17: {rom_len, rom_raw} = {3'd3, 5'b00010}; // R
            6'd18: {rom_len, rom_raw} = {3'd3, 5'b00000}; // S
            6'd19: {rom_len, rom_raw} = {3'd1, 5'b00001}; // T
            6'd20: {rom_len, rom_raw} = {3'd3, 5'b00001}; // U
            6'd21: {rom_len, rom_raw} = {3'd4, 5'b00001}; // V
            6'd22: {rom_len, rom_raw} = {3'd3, 5'b00011}; // W
            6'd23: {rom_len, rom_raw} = {3'd4, 5'b01001}; // X
            6'd24: {rom_len, rom_raw} = {3'd4, 5'b01011}; // Y
            6'd25: {rom_len, rom_raw} = {3'd4, 5'b01100}; // Z
            6'd26: {rom_len, rom_raw} = {3'd5, 5'b11111}; // 0
            6'd27: {rom_len, rom_raw} = {3'd5, 5'b01111}; // 1
            6'd28: {rom_len, rom_raw} = {3'd5, 5'b00111}; // 2
            6'd29: {rom_len, rom_raw} = {3'd5, 5'b00011}; // 3
            6'd30: {rom_len, rom_raw} = {3'd5, 5'b00001}; // 4
            6'd31: {rom_len, rom_raw} = {3'd5, 5'b00000}; // 5
            6'd32: {rom_len, rom_raw} = {3'd5, 5'b10000}; // 6
            6'd33: {rom_len, rom_raw} = {3'd5, 5'b11000}; // 7
            6'd34: {rom_len, rom_raw} = {3'd5, 5'b11100}; // 8
            6'd35: {rom_len, rom_raw} = {3'd5, 5'b11110}; // 9
            default: {rom_len, rom_raw} = 8'd0;
        endcase
        // left-align so the current element is always pat[4]
        rom_pat = rom_raw << (3'd5 - rom_len);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            pat_q   <= '0;
            rem_q   <= '0;
            gap_q   <= '0;
            sp_q    <= 1'b0;
            dot_q   <= 1'b0;
            dash_q  <= 1'b0;
            cs_q    <= 1'b0;
            ws_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            rem_q   <= rem_d;
            gap_q   <= gap_d;
            sp_q    <= sp_d;
            dot_q   <= dot_d;
            dash_q  <= dash_d;
            cs_q    <= cs_d;
            ws_q    <= ws_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        rem_d   = rem_q;
        gap_d   = gap_q;
        sp_d    = sp_q;
        case (state_q)
            IDLE: if (accept) begin
                sp_d = 1'b0;
                if (char_code < 6'd36) begin
                    state_d = ELEM;
                    pat_d   = rom_pat;
                    rem_d   = rom_len;
                end else if (char_code == 6'd36) begin
                    state_d = WSPACE;
                end else begin
                    state_d = ERR;
                end
            end
            ELEM: begin
                pat_d   = pat_q << 1;
                rem_d   = rem_q - 3'd1;
                gap_d   = 8'(GAP_CYCLES - 1);
                state_d = GAP;
            end
            GAP: begin
                // leaving at count 1 gives GAP_CYCLES-1 silent cycles
                if (gap_q <= 8'd1) begin
                    gap_d = 8'd0;
                    if (sp_q)              state_d = IDLE;
                    else if (rem_q != 3'd0) state_d = ELEM;
                    else                   state_d = CSPACE;
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
            CSPACE, WSPACE: begin
                sp_d    = 1'b1;
                gap_d   = 8'(GAP_CYCLES - 1);
                state_d = GAP;
            end
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // strobes are decoded from the next state so they appear as flop outputs
    always_comb begin
        dot_d  = (state_d == ELEM) && !pat_d[4];
        dash_d = (state_d == ELEM) &&  pat_d[4];
        cs_d   = (state_d == CSPACE);
        ws_d   = (state_d == WSPACE);
        err_d  = (state_d == ERR);
    end

    assign char_ready     = (state_q == IDLE);
    assign busy           = !char_ready;
    assign dot_out        = dot_q;
    assign dash_out       = dash_q;
    assign char_space_out = cs_q;
    assign word_space_out = ws_q;
    assign err            = err_q;

endmodule

// File: tb/tb_morse_char_sequencer.sv
// Directed bench for morse_char_sequencer at GAP_CYCLES 4 and 2, checking
// every cycle of each character against the Morse timing rules.
module tb_morse_char_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       valid = 1'b0;
    logic [5:0] code = '0;
    int         g = 4;
    int         checks = 0;
    int         errors = 0;

    logic       v4, v2;
    logic       rdy4, dot4, dash4, cs4, ws4, busy4, err4;
    logic       rdy2, dot2, dash2, cs2, ws2, busy2, err2;
    logic [6:0] obs;

    assign v4  = valid && (g == 4);
    assign v2  = valid && (g == 2);
    assign obs = (g == 4) ? {busy4, rdy4, dot4, dash4, cs4, ws4, err4}
                          : {busy2, rdy2, dot2, dash2, cs2, ws2, err2};

    always #5 clk = ~clk;

    morse_char_sequencer #(.GAP_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst), .char_valid(v4), .char_code(code),
        .char_ready(rdy4), .dot_out(dot4), .dash_out(dash4),
        .char_space_out(cs4), .word_space_out(ws4), .busy(busy4), .err(err4));

    morse_char_sequencer #(.GAP_CYCLES(2)) dut2 (
        .clk(clk), .rst(rst), .char_valid(v2), .char_code(code),
        .char_ready(rdy2), .dot_out(dot2), .dash_out(dash2),
        .char_space_out(cs2), .word_space_out(ws2), .busy(busy2), .err(err2));

    string morse_tab [36] = '{
        ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
        "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
        "..-", "...-", ".--", "-..-", "-.--", "--..",
        "-----", ".----", "..---", "...--", "....-",
        ".....", "-....", "--...", "---..", "----."};

    typedef struct {
        int         gap;
        logic [5:0] code;
        string      morse;   // expected element sequence ("" for space/invalid)
        bit         noise;   // wiggle valid/code while busy
    } vec_t;

    vec_t vecs [12];

    // {busy, ready, dot, dash, char_space, word_space, err}
    function automatic logic [6:0] mk(bit r, bit dt, bit ds, bit cs, bit ws, bit er);
        return {~r, r, dt, ds, cs, ws, er};
    endfunction

    task automatic chk(input string name, input int c, input logic [6:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s cycle T+%0d: got %b expected %b (busy,rdy,dot,dash,cs,ws,err)",
                     name, c, obs, exp);
        end
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (obs[5] !== 1'b1 && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (obs[5] !== 1'b1) begin
            errors++; checks++;
            $display("FAIL %s: ready never returned, got %b expected 1", name, obs[5]);
        end
    endtask

    task automatic run_char(input int gp, input logic [5:0] cd, input string m, input bit noise);
        int    n, len;
        bit    dt, ds, cs, ws, er;
        string nm;
        g  = gp;
        nm = $sformatf("code%0d_g%0d", cd, gp);
        wait_ready(nm);
        n = m.len();
        if (cd < 6'd36)       len = (n + 1) * gp;
        else if (cd == 6'd36) len = gp;
        else                  len = 1;
        @(negedge clk);
        valid = 1'b1;
        code  = cd;
        for (int c = 1; c <= len + 1; c++) begin
            @(posedge clk); #1;
            if (noise && c < len) begin
                valid = 1'b1;
                code  = 6'($urandom_range(0, 63));
            end else begin
                valid = 1'b0;
            end
            {dt, ds, cs, ws, er} = '0;
            if (cd < 6'd36) begin
                if ((c - 1) % gp == 0) begin
                    if ((c - 1) / gp < n) begin
                        if (m[(c - 1) / gp] == 8'h2D) ds = 1'b1;
                        else                          dt = 1'b1;
                    end else if ((c - 1) / gp == n) begin
                        cs = 1'b1;
                    end
                end
            end else if (cd == 6'd36) begin
                ws = (c == 1);
            end else begin
                er = (c == 1);
            end
            chk(nm, c, mk(c == len + 1, dt, ds, cs, ws, er));
        end
    endtask

    initial begin
        vecs[0]  = '{4, 6'd4,  ".",     1'b0};  // E
        vecs[1]  = '{4, 6'd0,  ".-",    1'b0};  // A
        vecs[2]  = '{4, 6'd19, "-",     1'b0};  // T
        vecs[3]  = '{4, 6'd14, "---",   1'b1};  // O, inputs wiggled while busy
        vecs[4]  = '{4, 6'd36, "",      1'b1};  // word space
        vecs[5]  = '{4, 6'd40, "",      1'b0};  // invalid
        vecs[6]  = '{4, 6'd63, "",      1'b0};  // invalid upper bound
        vecs[7]  = '{4, 6'd16, "--.-",  1'b1};  // Q
        vecs[8]  = '{4, 6'd31, ".....", 1'b0};  // 5
        vecs[9]  = '{4, 6'd35, "----.", 1'b0};  // 9
        vecs[10] = '{2, 6'd25, "--..",  1'b1};  // Z
        vecs[11] = '{2, 6'd37, "",      1'b0};  // first invalid code

        // reset state, both instances
        #12;
        g = 4; chk("reset_g4", 0, mk(1, 0, 0, 0, 0, 0));
        g = 2; chk("reset_g2", 0, mk(1, 0, 0, 0, 0, 0));
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        g = 4; chk("after_reset_g4", 0, mk(1, 0, 0, 0, 0, 0));

        foreach (vecs[i]) run_char(vecs[i].gap, vecs[i].code, vecs[i].morse, vecs[i].noise);

        // G=2: '0' then word space held valid, accepted the cycle ready rises
        g = 2;
        wait_ready("b2b");
        @(negedge clk); valid = 1'b1; code = 6'd26;
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk); #1;
            if (c == 1)  code  = 6'd36;
            chk("b2b", c, mk(c == 13 || c == 16,
                             1'b0,
                             (c == 1 || c == 3 || c == 5 || c == 7 || c == 9),
                             c == 11, c == 14, 1'b0));
            if (c == 14) valid = 1'b0;
        end

        // G=4: reset asserted while the second dot of 'S' is on the wire
        g = 4;
        wait_ready("rst_mid");
        @(negedge clk); valid = 1'b1; code = 6'd18;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            valid = 1'b0;
            chk("rst_mid", c, mk(0, c == 1 || c == 5, 0, 0, 0, 0));
        end
        rst = 1'b0;
        #1 chk("rst_async", 5, mk(1, 0, 0, 0, 0, 0));
        @(negedge clk); rst = 1'b1;
        for (int c = 6; c <= 20; c++) begin
            @(posedge clk); #1;
            chk("rst_discard", c, mk(1, 0, 0, 0, 0, 0));
        end

        // random stream at G=2 against the bench's own Morse table
        for (int i = 0; i < 25; i++) begin
            logic [5:0] rc;
            rc = 6'($urandom_range(0, 36));
            run_char(2, rc, (rc < 6'd36) ? morse_tab[rc] : "", 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
